// File: rtl/code2421_pkg.sv
// Shared constants for the 2421 (Aiken) decade stage and its display:
// legal code points, the error marker and the active-low segment font.
package code2421_pkg;

    localparam logic [3:0] code_0 = 4'b0000;
    localparam logic [3:0] code_1 = 4'b0001;
    localparam logic [3:0] code_2 = 4'b0010;
    localparam logic [3:0] code_3 = 4'b0011;
    localparam logic [3:0] code_4 = 4'b0100;
    localparam logic [3:0] code_5 = 4'b1011;
    localparam logic [3:0] code_6 = 4'b1100;
    localparam logic [3:0] code_7 = 4'b1101;
    localparam logic [3:0] code_8 = 4'b1110;
    localparam logic [3:0] code_9 = 4'b1111;

    localparam logic [3:0] err_marker = 4'hF;

    // Segment order {g,f,e,d,c,b,a}, a segment lights when its bit is 0.
    localparam logic [6:0] font_0     = 7'b1000000;
    localparam logic [6:0] font_1     = 7'b1111001;
    localparam logic [6:0] font_2     = 7'b0100100;
    localparam logic [6:0] font_3     = 7'b0110000;
    localparam logic [6:0] font_4     = 7'b0011001;
    localparam logic [6:0] font_5     = 7'b0010010;
    localparam logic [6:0] font_6     = 7'b0000010;
    localparam logic [6:0] font_7     = 7'b1111000;
    localparam logic [6:0] font_8     = 7'b0000000;
    localparam logic [6:0] font_9     = 7'b0010000;
    localparam logic [6:0] font_err   = 7'b0000110;
    localparam logic [6:0] font_blank = 7'b1111111;

    // Illegal codes 0101..1010 map to err_marker.
    function automatic logic [3:0] decode_2421(input logic [3:0] code);
        logic [3:0] bcd;
        case (code)
            code_0:  bcd = 4'd0;
            code_1:  bcd = 4'd1;
            code_2:  bcd = 4'd2;
            code_3:  bcd = 4'd3;
            code_4:  bcd = 4'd4;
            code_5:  bcd = 4'd5;
            code_6:  bcd = 4'd6;
            code_7:  bcd = 4'd7;
            code_8:  bcd = 4'd8;
            code_9:  bcd = 4'd9;
            default: bcd = err_marker;
        endcase
        return bcd;
    endfunction

    function automatic logic is_illegal_2421(input logic [3:0] code);
        return (code >= 4'b0101) && (code <= 4'b1010);
    endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational BCD-to-seven-segment font, active-low {g..a}.
// Shows "E" for the error marker and blanks any other non-digit value.
module seg7_font
    import code2421_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = font_blank;
        case (value)
            4'd0:       seg = font_0;
            4'd1:       seg = font_1;
            4'd2:       seg = font_2;
            4'd3:       seg = font_3;
            4'd4:       seg = font_4;
            4'd5:       seg = font_5;
            4'd6:       seg = font_6;
            4'd7:       seg = font_7;
            4'd8:       seg = font_8;
            4'd9:       seg = font_9;
            err_marker: seg = font_err;
            default:    seg = font_blank;
        endcase
    end

endmodule

// File: rtl/code2421_display.sv
// Decodes a 2421 units digit, counts carry pulses into a tens digit and
// drives a two-digit multiplexed active-low seven-segment display.
module code2421_display
    import code2421_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned SCAN_W   = $clog2(SCAN_DIV) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_2421,
    input  logic       carry_in,
    input  logic       clr,
    output logic [3:0] bcd_units,
    output logic [3:0] bcd_tens,
    output logic [1:0] an,
    output logic [6:0] seg,
    output logic       code_err,
    output logic       tens_ovf
);

    logic [3:0]        unit_q;
    logic [3:0]        tens_q, tens_d;
    logic              carry_q;
    logic              code_err_q, code_err_d;
    logic              tens_ovf_q, tens_ovf_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              sel_q, sel_d;
    logic              carry_rise;
    logic [3:0]        disp_val;

    assign carry_rise = carry_in & ~carry_q;

    always_comb begin
        tens_d     = tens_q;
        code_err_d = code_err_q;
        tens_ovf_d = tens_ovf_q;
        if (clr) begin
            // A carry edge coincident with clr is dropped; carry_q still
            // tracks carry_in so a held carry cannot fire afterwards.
            tens_d     = 4'd0;
            code_err_d = 1'b0;
            tens_ovf_d = 1'b0;
        end else begin
            if (is_illegal_2421(digit_2421)) begin
                code_err_d = 1'b1;
            end
            if (carry_rise) begin
                if (tens_q == 4'd9) begin
                    tens_d     = 4'd0;
                    tens_ovf_d = 1'b1;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        sel_d      = sel_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            sel_d      = ~sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            unit_q     <= code_0;
            tens_q     <= 4'd0;
            carry_q    <= 1'b0;
            code_err_q <= 1'b0;
            tens_ovf_q <= 1'b0;
            scan_cnt_q <= '0;
            sel_q      <= 1'b0;
        end else begin
            unit_q     <= digit_2421;
            tens_q     <= tens_d;
            carry_q    <= carry_in;
            code_err_q <= code_err_d;
            tens_ovf_q <= tens_ovf_d;
            scan_cnt_q <= scan_cnt_d;
            sel_q      <= sel_d;
        end
    end

    assign bcd_units = decode_2421(unit_q);
    assign bcd_tens  = tens_q;
    assign code_err  = code_err_q;
    assign tens_ovf  = tens_ovf_q;

    assign an       = sel_q ? 2'b01 : 2'b10;
    assign disp_val = sel_q ? tens_q : bcd_units;

    seg7_font u_font (
        .value (disp_val),
        .seg   (seg)
    );

endmodule
